// File: rtl/time_code_generator.sv
// time_code_generator: hour:minute clock advanced by a tick prescaler, with a checked time-set command
// and a registered lighting-period code decoded from the current hour.
module time_code_generator #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [3:0] tcode,
  output logic       tcode_changed,
  output logic       set_err
);
  localparam int PW = $clog2(TICKS_PER_MIN);
  logic [PW-1:0] presc;
  logic          set_ok;
  logic          min_step;
  logic          hour_step;
  logic [3:0]    period;
  always_comb begin
    set_ok    = set_valid && set_hour <= 5'd23 && set_min <= 6'd59;
    min_step  = tick_en && presc == PW'(TICKS_PER_MIN - 1);
    hour_step = min_step && minute == 6'd59;
    period    = (hour >= 5'd10 && hour <= 5'd15)                        ? 4'b0000 :
                ((hour >= 5'd7 && hour <= 5'd9) || hour == 5'd16 || hour == 5'd17) ? 4'b1000 :
                (hour == 5'd6 || hour == 5'd18)                         ? 4'b0100 :
                (hour >= 5'd19 && hour <= 5'd21)                        ? 4'b0010 :
                                                                          4'b0001;
  end
  // tcode lags hour by one cycle; reset value matches the decode of hour 0 so no pulse follows reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      hour          <= '0;
      minute        <= '0;
      tcode         <= 4'b0001;
      tcode_changed <= 1'b0;
      set_err       <= 1'b0;
    end else begin
      set_err       <= set_valid && !set_ok;
      tcode         <= period;
      tcode_changed <= period != tcode;
      if (set_ok) begin
        hour   <= set_hour;
        minute <= set_min;
        presc  <= '0;
      end else if (tick_en) begin
        presc <= min_step ? '0 : presc + 1'b1;
        if (min_step) minute <= hour_step ? 6'd0 : minute + 6'd1;
        if (hour_step) hour <= hour == 5'd23 ? 5'd0 : hour + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_time_code_generator.sv
// tb_time_code_generator: directed and random stimulus checked against a minutes-of-day reference model.
module tb_time_code_generator;
  localparam int TPM = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [3:0] tcode;
  logic       tcode_changed;
  logic       set_err;
  int total = 0;
  int bad = 0;
  int m_mod = 0;
  int m_cnt = 0;
  int m_tc = 1;
  int m_chg = 0;
  int m_err = 0;
  int tbl [24] = '{1, 1, 1, 1, 1, 1, 4, 8, 8, 8, 0, 0, 0, 0, 0, 0, 8, 8, 4, 2, 2, 2, 1, 1};
  time_code_generator #(.TICKS_PER_MIN(TPM)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .set_valid(set_valid),
    .set_hour(set_hour), .set_min(set_min), .hour(hour), .minute(minute),
    .tcode(tcode), .tcode_changed(tcode_changed), .set_err(set_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit r, input bit t, input bit sv, input int sh, input int sm);
    int nt;
    bit legal;
    rst = r;
    tick_en = t;
    set_valid = sv;
    set_hour = 5'(sh);
    set_min = 6'(sm);
    @(posedge clk);
    #1;
    if (r) begin
      m_mod = 0; m_cnt = 0; m_tc = 1; m_chg = 0; m_err = 0;
    end else begin
      nt = tbl[m_mod / 60];
      m_chg = int'(nt != m_tc);
      m_tc = nt;
      legal = sv && sh <= 23 && sm <= 59;
      m_err = int'(sv && !legal);
      if (legal) begin
        m_mod = sh * 60 + sm;
        m_cnt = 0;
      end else if (t) begin
        m_cnt++;
        if (m_cnt == TPM) begin
          m_cnt = 0;
          m_mod = (m_mod + 1) % 1440;
        end
      end
    end
    chk("hour", hour, m_mod / 60);
    chk("minute", minute, m_mod % 60);
    chk("tcode", tcode, m_tc);
    chk("tcode_changed", tcode_changed, m_chg);
    chk("set_err", set_err, m_err);
  endtask
  initial begin
    int hs [7] = '{5, 6, 9, 15, 17, 18, 21};
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_tcode", tcode, 4'b0001);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 58);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    chk("roll_hour", hour, 1);
    chk("roll_min", minute, 0);
    foreach (hs[k]) begin
      cyc(0, 0, 1, hs[k], 59);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("edge_pulse", tcode_changed, 1);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 1, 23, 59);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    chk("wrap_tcode", tcode, 4'b0001);
    cyc(0, 0, 1, 24, 10);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 60);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 12, 30);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 8, 15);
    cyc(0, 0, 0, 0, 0);
    chk("collide_tcode", tcode, 4'b1000);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 18, 0);
    cyc(1, 0, 0, 0, 0);
    chk("midrst_chg", tcode_changed, 0);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
          $urandom_range(31), $urandom_range(63));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_code_generator.md
# time_code_generator

Time-of-day sequencer that sits directly upstream of the lighting system. It keeps an hour:minute clock advanced by a tick enable and decodes the current hour into the 4-bit period code `tcode`, which drives the lighting system's `tcode` input. It also accepts a single-cycle time-set command from the house controller.

## Interface

Parameters:
- `TICKS_PER_MIN`, default 60: number of `tick_en` pulses per minute; legal range is ≥ 2.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick_en`  in  1  time-base enable, one pulse per tick.
- `set_valid`  in  1  single-cycle time-load strobe.
- `set_hour`  in  5  hour to load, legal 0–23.
- `set_min`  in  6  minute to load, legal 0–59.
- `hour`  out  5  current hour, registered.
- `minute`  out  6  current minute, registered.
- `tcode`  out  4  period code, registered.
- `tcode_changed`  out  1  one-cycle pulse when `tcode` takes a new value.
- `set_err`  out  1  one-cycle pulse when a set command is rejected.

## Operation

Prescaler:
- `presc` is `$clog2(TICKS_PER_MIN)` bits wide.
- On a `tick_en` cycle, if `presc == TICKS_PER_MIN-1`, `presc` returns to 0 and a minute step occurs.
- Otherwise a `tick_en` cycle increments `presc`.
- With `tick_en` low, `presc` holds.

Minute step:
- `minute` increments; 59 wraps to 0 and causes an hour step.
- `hour` increments on an hour step; 23 wraps to 0.

Set command:
- Legal when `set_valid=1`, `set_hour ≤ 23` and `set_min ≤ 59`.
- A legal set loads `hour` and `minute` and clears `presc`.
- If `set_hour > 23` or `set_min > 59`, no register changes and `set_err` pulses on the next cycle.

Priority:
- `rst` overrides a set command, which overrides a tick.
- A legal set wins over a coincident `tick_en`; that tick is dropped.

Period decode (from the registered `hour`, then registered into `tcode`):
- 10–15 → S4 = 0000
- 07–09 and 16–17 → S3 = 1000
- 06 and 18 → S2 = 0100
- 19–21 → S1 = 0010
- 22–23 and 00–05 → S0 = 0001

Every hour value maps to exactly one period. No other `tcode` encodings are ever driven.

`tcode_changed`:
- Asserted on the cycle `tcode` is updated to a value different from its previous value.
- Not asserted when a set or step leaves the period unchanged.

## Timing

Reset values:
- `presc`=0, `hour`=0, `minute`=0
- `tcode`=0001 (S0, matching hour 0)
- `tcode_changed`=0, `set_err`=0
- No `tcode_changed` pulse on the first cycle after reset.

Latencies:
- `hour` and `minute` update at the clock edge on which the stepping `tick_en` or legal `set_valid` is sampled.
- `tcode` follows `hour` with one cycle of latency; `tcode_changed` is high in that same cycle.
- `set_err` goes high one cycle after the rejected `set_valid`.

Boundary conditions:
- **Back-to-back sets:** each set is evaluated independently, one per cycle.
- **Continuous `tick_en`:** with `tick_en` high every cycle, minutes advance every `TICKS_PER_MIN` cycles.
- **Reset mid-count:** asserting `rst` at any point returns all registers to their reset values on that edge, including a pending `tcode` update or `set_err` pulse.
- **23:59 wrap:** 23:59 → 00:00 in a single edge; `tcode` stays 0001, with no `tcode_changed` pulse.

## Test plan

- **Reset:** assert `rst` for 2 cycles, then release → `hour`=0, `minute`=0, `tcode`=0001, and no `tcode_changed` or `set_err` pulses for 5 cycles.
- **Minute and hour roll:** `TICKS_PER_MIN`=4, `tick_en` held high, start from 00:58 → 00:59 after 4 ticks and 01:00 after 8 ticks, with `tcode` staying 0001.
- **Period edge:** set 05:59, then 4 ticks → `hour`=6 on the stepping edge; one cycle later `tcode`=0100 with a single-cycle `tcode_changed`. Sweep the 06, 07, 10, 16, 18, 19 and 22 boundaries similarly, expecting 0100, 1000, 0000, 1000, 0100, 0010, 0001.
- **Invalid set:** set_hour=24 with set_min=10, then set_hour=5 with set_min=60 → time unchanged and `set_err` pulses once, one cycle after each command.
- **Set vs tick collision:** from 12:30 with `presc`=3 (`TICKS_PER_MIN`=4), drive `set_valid` (08:15) and `tick_en` together → 08:15 with `presc`=0, then `tcode`=1000 with `tcode_changed` on the following cycle.
- **Reset mid-operation:** set 18:00 and assert `rst` on the cycle after the set, before `tcode` has updated → next cycle shows 00:00, `tcode`=0001 and `tcode_changed`=0.
